rf_writeback: RTL and testbench

Write-side driver for the 4 x 16-bit pipelined-CPU register file. It accepts writeback results from two producers, the ALU path and the load path, through valid/ready handshakes. Results are queued in program order in a small FIFO and retired one per cycle onto the register file's single write port (write, addr3, data3). It also exports a pending-write mask and a youngest-match bypass, so the decode stage can stall or forward around in-flight writes.

---
 rtl/rf_pkg.sv | 14 +
 rtl/rf_writeback_wb_fifo.sv | 63 ++++++
 rtl/rf_writeback.sv | 135 +++++++++++++
 tb/tb_rf_writeback.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// rf_pkg: shared widths and the writeback queue entry type for the
// register-file write-side driver.
package rf_pkg;

  localparam int unsigned ADDR_W   = 2;
  localparam int unsigned DATA_W   = 16;
  localparam int unsigned NUM_REGS = 4;

  typedef struct packed {
    logic [ADDR_W-1:0] dest;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/rf_writeback_wb_fifo.sv
// wb_fifo: DEPTH-entry writeback queue with two ordered push ports
// (port 0 is older than port 1) and one pop. Entries are also exposed
// in age order (index 0 = oldest) so the parent can build the pending
// mask and the bypass search.
module wb_fifo
  import rf_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push0,
  input  wb_entry_t              din0,
  input  logic                   push1,
  input  wb_entry_t              din1,
  input  logic                   pop,
  output logic [$clog2(DEPTH):0] count,
  output wb_entry_t              ordered [DEPTH],
  output logic [DEPTH-1:0]       ord_valid
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  wb_entry_t     mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr1;

  assign wr_ptr1 = wr_ptr + PW'(1);

  // Pointer and occupancy update; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(push0) + PW'(push1);
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push0) + CW'(push1) - CW'(pop);
    end
  end

  // Entry storage; contents are only meaningful where qualified by count.
  // A lone port-1 push takes the slot port 0 would have used.
  always_ff @(posedge clk) begin
    if (push0)
      mem[wr_ptr] <= din0;
    if (push1)
      mem[push0 ? wr_ptr1 : wr_ptr] <= din1;
  end

  // Age-ordered view of the queue, oldest first.
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      ordered[i]   = mem[rd_ptr + PW'(i)];
      ord_valid[i] = (CW'(i) < count);
    end
  end

endmodule

// File: rtl/rf_writeback.sv
// rf_writeback: write-side driver for the 4 x 16-bit register file.
// Accepts load and ALU results via valid/ready, queues them in program
// order, retires one per cycle onto the write port, and exports a
// pending-write mask plus a youngest-match bypass.
// Build option: define RF_WB_FWD_EN to compile in the bypass search;
// without it fwd_hit*/fwd_data* are tied to zero.
module rf_writeback
  import rf_pkg::wb_entry_t;
  import rf_pkg::NUM_REGS;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = rf_pkg::DATA_W,
  parameter int unsigned ADDR_W = rf_pkg::ADDR_W
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                ld_valid,
  output logic                ld_ready,
  input  logic [ADDR_W-1:0]   ld_dest,
  input  logic [DATA_W-1:0]   ld_data,
  input  logic                alu_valid,
  output logic                alu_ready,
  input  logic [ADDR_W-1:0]   alu_dest,
  input  logic [DATA_W-1:0]   alu_data,
  output logic                rf_write,
  output logic [ADDR_W-1:0]   rf_addr,
  output logic [DATA_W-1:0]   rf_data,
  output logic [NUM_REGS-1:0] pend_mask,
  input  logic [ADDR_W-1:0]   rd_addr1,
  input  logic [ADDR_W-1:0]   rd_addr2,
  output logic                fwd_hit1,
  output logic                fwd_hit2,
  output logic [DATA_W-1:0]   fwd_data1,
  output logic [DATA_W-1:0]   fwd_data2
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [CW-1:0]    count;
  logic [CW-1:0]    free;
  wb_entry_t        ordered [DEPTH];
  logic [DEPTH-1:0] ord_valid;
  wb_entry_t        ld_entry;
  wb_entry_t        alu_entry;
  logic             ld_push;
  logic             alu_push;
  logic             pop;

  // Readiness is based on occupancy before this cycle's pop. Since a
  // non-empty queue always pops, occupancy settles at DEPTH-1 at most.
  assign free      = CW'(DEPTH) - count;
  assign ld_ready  = (free >= CW'(1));
  assign alu_ready = (free >= CW'(2)) || ((free == CW'(1)) && !ld_valid);
  assign ld_push   = ld_valid && ld_ready;
  assign alu_push  = alu_valid && alu_ready;
  assign pop       = (count != '0);

  assign ld_entry  = '{dest: ld_dest, data: ld_data};
  assign alu_entry = '{dest: alu_dest, data: alu_data};

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push0     (ld_push),
    .din0      (ld_entry),
    .push1     (alu_push),
    .din1      (alu_entry),
    .pop       (pop),
    .count     (count),
    .ordered   (ordered),
    .ord_valid (ord_valid)
  );

  // Output register: head entry drives the write port for one cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rf_write <= 1'b0;
      rf_addr  <= '0;
      rf_data  <= '0;
    end else if (pop) begin
      rf_write <= 1'b1;
      rf_addr  <= ordered[0].dest;
      rf_data  <= ordered[0].data;
    end else begin
      rf_write <= 1'b0;
    end
  end

  // Pending mask: every queued destination plus the write in flight.
  always_comb begin
    pend_mask = '0;
    for (int unsigned i = 0; i < DEPTH; i++)
      if (ord_valid[i])
        pend_mask[ordered[i].dest] = 1'b1;
    if (rf_write)
      pend_mask[rf_addr] = 1'b1;
  end

`ifdef RF_WB_FWD_EN
  // Bypass: output register first, then queue oldest to youngest, so
  // later matches override and the youngest write wins.
  always_comb begin
    fwd_hit1  = 1'b0;
    fwd_data1 = '0;
    fwd_hit2  = 1'b0;
    fwd_data2 = '0;
    if (rf_write && (rf_addr == rd_addr1)) begin
      fwd_hit1  = 1'b1;
      fwd_data1 = rf_data;
    end
    if (rf_write && (rf_addr == rd_addr2)) begin
      fwd_hit2  = 1'b1;
      fwd_data2 = rf_data;
    end
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (ord_valid[i] && (ordered[i].dest == rd_addr1)) begin
        fwd_hit1  = 1'b1;
        fwd_data1 = ordered[i].data;
      end
      if (ord_valid[i] && (ordered[i].dest == rd_addr2)) begin
        fwd_hit2  = 1'b1;
        fwd_data2 = ordered[i].data;
      end
    end
  end
`else
  logic unused_rd;
  assign unused_rd = ^{rd_addr1, rd_addr2};
  assign fwd_hit1  = 1'b0;
  assign fwd_hit2  = 1'b0;
  assign fwd_data1 = '0;
  assign fwd_data2 = '0;
`endif

endmodule

// File: tb/tb_rf_writeback.sv
// tb_rf_writeback: directed self-checking bench for rf_writeback.
module tb_rf_writeback;

`ifdef RF_WB_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ld_valid = 1'b0;
  logic        ld_ready;
  logic [1:0]  ld_dest = '0;
  logic [15:0] ld_data = '0;
  logic        alu_valid = 1'b0;
  logic        alu_ready;
  logic [1:0]  alu_dest = '0;
  logic [15:0] alu_data = '0;
  logic        rf_write;
  logic [1:0]  rf_addr;
  logic [15:0] rf_data;
  logic [3:0]  pend_mask;
  logic [1:0]  rd_addr1 = '0;
  logic [1:0]  rd_addr2 = '0;
  logic        fwd_hit1;
  logic        fwd_hit2;
  logic [15:0] fwd_data1;
  logic [15:0] fwd_data2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rf_writeback dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .ld_valid  (ld_valid),
    .ld_ready  (ld_ready),
    .ld_dest   (ld_dest),
    .ld_data   (ld_data),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready),
    .alu_dest  (alu_dest),
    .alu_data  (alu_data),
    .rf_write  (rf_write),
    .rf_addr   (rf_addr),
    .rf_data   (rf_data),
    .pend_mask (pend_mask),
    .rd_addr1  (rd_addr1),
    .rd_addr2  (rd_addr2),
    .fwd_hit1  (fwd_hit1),
    .fwd_hit2  (fwd_hit2),
    .fwd_data1 (fwd_data1),
    .fwd_data2 (fwd_data2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ld_valid  = 1'b0;
    alu_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    idle();
    tick();
    tick();
    total++; if (rf_write !== 1'b0) begin bad++; $display("FAIL reset_rf_write got=%0b want=0", rf_write); end
    total++; if (pend_mask !== 4'b0000) begin bad++; $display("FAIL reset_pend got=%b want=0000", pend_mask); end
    total++; if (fwd_hit1 !== 1'b0) begin bad++; $display("FAIL reset_fwd_hit1 got=%0b want=0", fwd_hit1); end
    reset_n = 1'b1;
    #1;
    total++; if ({ld_ready, alu_ready} !== 2'b11) begin bad++; $display("FAIL reset_ready got=%b want=11", {ld_ready, alu_ready}); end
    // queue three entries, then reset mid-stream
    ld_valid = 1'b1; ld_dest = 2'd0; ld_data = 16'h1111;
    alu_valid = 1'b1; alu_dest = 2'd1; alu_data = 16'h2222;
    tick();
    ld_dest = 2'd2; ld_data = 16'h3333;
    alu_dest = 2'd3; alu_data = 16'h4444;
    tick();
    total++; if ({rf_write, rf_data} !== {1'b1, 16'h1111}) begin bad++; $display("FAIL mid_first_write got=%0b/%h want=1/1111", rf_write, rf_data); end
    total++; if (pend_mask !== 4'b1111) begin bad++; $display("FAIL mid_pend got=%b want=1111", pend_mask); end
    idle();
    reset_n = 1'b0;
    #1;
    total++; if (rf_write !== 1'b0) begin bad++; $display("FAIL async_rf_write got=%0b want=0", rf_write); end
    total++; if (pend_mask !== 4'b0000) begin bad++; $display("FAIL async_pend got=%b want=0000", pend_mask); end
    tick();
    reset_n = 1'b1;
    #1;
    total++; if ({ld_ready, alu_ready} !== 2'b11) begin bad++; $display("FAIL post_reset_ready got=%b want=11", {ld_ready, alu_ready}); end
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if ({rf_write, pend_mask} !== 5'b0) begin bad++; $display("FAIL post_reset_quiet cyc=%0d got=%0b/%b want=0/0000", i, rf_write, pend_mask); end
    end
  endtask

  task automatic test_single_load();
    ld_valid = 1'b1; ld_dest = 2'd2; ld_data = 16'h1234;
    tick();
    idle();
    total++; if ({rf_write, pend_mask} !== {1'b0, 4'b0100}) begin bad++; $display("FAIL single_queued got=%0b/%b want=0/0100", rf_write, pend_mask); end
    tick();
    total++; if ({rf_write, rf_addr, rf_data} !== {1'b1, 2'd2, 16'h1234}) begin bad++; $display("FAIL single_write got=%0b/%0d/%h want=1/2/1234", rf_write, rf_addr, rf_data); end
    total++; if (pend_mask !== 4'b0100) begin bad++; $display("FAIL single_pend_drive got=%b want=0100", pend_mask); end
    tick();
    total++; if ({rf_write, pend_mask} !== 5'b0) begin bad++; $display("FAIL single_retired got=%0b/%b want=0/0000", rf_write, pend_mask); end
    total++; if ({rf_addr, rf_data} !== {2'd2, 16'h1234}) begin bad++; $display("FAIL single_hold got=%0d/%h want=2/1234", rf_addr, rf_data); end
  endtask

  task automatic test_dual_same_dest();
    logic [15:0] exp_fwd;
    exp_fwd = FWD ? 16'h5555 : 16'h0000;
    rd_addr1 = 2'd1; rd_addr2 = 2'd0;
    ld_valid = 1'b1; ld_dest = 2'd1; ld_data = 16'hAAAA;
    alu_valid = 1'b1; alu_dest = 2'd1; alu_data = 16'h5555;
    tick();
    idle();
    total++; if ({fwd_hit1, fwd_data1} !== {FWD, exp_fwd}) begin bad++; $display("FAIL dual_fwd_queued got=%0b/%h want=%0b/%h", fwd_hit1, fwd_data1, FWD, exp_fwd); end
    total++; if (fwd_hit2 !== 1'b0) begin bad++; $display("FAIL dual_fwd2_miss got=%0b want=0", fwd_hit2); end
    total++; if ({rf_write, pend_mask} !== {1'b0, 4'b0010}) begin bad++; $display("FAIL dual_pend got=%0b/%b want=0/0010", rf_write, pend_mask); end
    tick();
    total++; if ({rf_write, rf_addr, rf_data} !== {1'b1, 2'd1, 16'hAAAA}) begin bad++; $display("FAIL dual_first got=%0b/%0d/%h want=1/1/aaaa", rf_write, rf_addr, rf_data); end
    total++; if ({fwd_hit1, fwd_data1} !== {FWD, exp_fwd}) begin bad++; $display("FAIL dual_fwd_young got=%0b/%h want=%0b/%h", fwd_hit1, fwd_data1, FWD, exp_fwd); end
    tick();
    total++; if ({rf_write, rf_addr, rf_data} !== {1'b1, 2'd1, 16'h5555}) begin bad++; $display("FAIL dual_second got=%0b/%0d/%h want=1/1/5555", rf_write, rf_addr, rf_data); end
    total++; if ({fwd_hit1, fwd_data1} !== {FWD, exp_fwd}) begin bad++; $display("FAIL dual_fwd_outreg got=%0b/%h want=%0b/%h", fwd_hit1, fwd_data1, FWD, exp_fwd); end
    tick();
    total++; if ({rf_write, pend_mask, fwd_hit1} !== 6'b0) begin bad++; $display("FAIL dual_done got=%0b/%b/%0b want=0/0000/0", rf_write, pend_mask, fwd_hit1); end
  endtask

  task automatic test_backpressure();
    ld_valid = 1'b1; ld_dest = 2'd0; ld_data = 16'h0101;
    alu_valid = 1'b1; alu_dest = 2'd1; alu_data = 16'h0202;
    tick();
    total++; if ({rf_write, pend_mask} !== {1'b0, 4'b0011}) begin bad++; $display("FAIL bp_two got=%0b/%b want=0/0011", rf_write, pend_mask); end
    ld_dest = 2'd2; ld_data = 16'h0303;
    alu_dest = 2'd3; alu_data = 16'h0404;
    #1;
    total++; if ({ld_ready, alu_ready} !== 2'b11) begin bad++; $display("FAIL bp_free2_ready got=%b want=11", {ld_ready, alu_ready}); end
    tick();
    total++; if ({rf_write, rf_data, pend_mask} !== {1'b1, 16'h0101, 4'b1111}) begin bad++; $display("FAIL bp_three got=%0b/%h/%b want=1/0101/1111", rf_write, rf_data, pend_mask); end
    ld_dest = 2'd0; ld_data = 16'h0505;
    alu_dest = 2'd1; alu_data = 16'h0606;
    #1;
    total++; if ({ld_ready, alu_ready} !== 2'b10) begin bad++; $display("FAIL bp_both_offered got=%b want=10", {ld_ready, alu_ready}); end
    ld_valid = 1'b0;
    #1;
    total++; if (alu_ready !== 1'b1) begin bad++; $display("FAIL bp_alu_alone got=%0b want=1", alu_ready); end
    ld_valid = 1'b1;
    #1;
    tick();
    total++; if (rf_data !== 16'h0202) begin bad++; $display("FAIL bp_ret2 got=%h want=0202", rf_data); end
    total++; if ({ld_ready, alu_ready} !== 2'b10) begin bad++; $display("FAIL bp_still_three got=%b want=10", {ld_ready, alu_ready}); end
    idle();
    tick();
    total++; if (rf_data !== 16'h0303) begin bad++; $display("FAIL bp_ret3 got=%h want=0303", rf_data); end
    tick();
    total++; if (rf_data !== 16'h0404) begin bad++; $display("FAIL bp_ret4 got=%h want=0404", rf_data); end
    tick();
    total++; if ({rf_write, rf_addr, rf_data} !== {1'b1, 2'd0, 16'h0505}) begin bad++; $display("FAIL bp_ret5 got=%0b/%0d/%h want=1/0/0505", rf_write, rf_addr, rf_data); end
    tick();
    total++; if (rf_write !== 1'b0) begin bad++; $display("FAIL bp_refused_not_written got=%0b want=0", rf_write); end
  endtask

  task automatic test_wrap_around();
    for (int i = 0; i < 10; i++) begin
      alu_valid = 1'b1;
      alu_dest  = 2'(i % 4);
      alu_data  = 16'(i);
      #1;
      total++; if (alu_ready !== 1'b1) begin bad++; $display("FAIL wrap_ready i=%0d got=%0b want=1", i, alu_ready); end
      tick();
      if (i > 0) begin
        total++; if ({rf_write, rf_addr, rf_data} !== {1'b1, 2'((i - 1) % 4), 16'(i - 1)}) begin bad++; $display("FAIL wrap_ret i=%0d got=%0b/%0d/%0d want=1/%0d/%0d", i - 1, rf_write, rf_addr, rf_data, (i - 1) % 4, i - 1); end
      end
    end
    idle();
    tick();
    total++; if ({rf_write, rf_addr, rf_data} !== {1'b1, 2'd1, 16'd9}) begin bad++; $display("FAIL wrap_last got=%0b/%0d/%0d want=1/1/9", rf_write, rf_addr, rf_data); end
    tick();
    total++; if (rf_write !== 1'b0) begin bad++; $display("FAIL wrap_drain got=%0b want=0", rf_write); end
  endtask

  task automatic test_macro_off();
    logic [15:0] exp_fwd;
    exp_fwd = FWD ? 16'h0F0F : 16'h0000;
    rd_addr1 = 2'd3;
    ld_valid = 1'b1; ld_dest = 2'd3; ld_data = 16'h0F0F;
    tick();
    idle();
    total++; if (pend_mask[3] !== 1'b1) begin bad++; $display("FAIL macro_pend3 got=%0b want=1", pend_mask[3]); end
    total++; if ({fwd_hit1, fwd_data1} !== {FWD, exp_fwd}) begin bad++; $display("FAIL macro_fwd got=%0b/%h want=%0b/%h", fwd_hit1, fwd_data1, FWD, exp_fwd); end
    tick();
    tick();
    total++; if (pend_mask !== 4'b0000) begin bad++; $display("FAIL macro_drain got=%b want=0000", pend_mask); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_load();
    test_dual_same_dest();
    test_backpressure();
    test_wrap_around();
    test_macro_off();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
